// File: rtl/btn_event_arbiter_pkg.sv
// Shared encodings and constants for the button event arbiter.
package btn_event_arbiter_pkg;

  localparam int N_CH = 4;
  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    D_ZERO = 1'b0,
    D_ONE  = 1'b1
  } det_state_e;

endpackage

// File: rtl/edge_tick_cell.sv
// Mealy rising-edge detector: tick is combinational while in ZERO with level high.
module edge_tick_cell
  import btn_event_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);

  det_state_e r_state, w_state_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= D_ZERO;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    tick       = 1'b0;
    case (r_state)
      D_ZERO: if (level) begin
        tick       = 1'b1;
        w_state_nx = D_ONE;
      end
      D_ONE:   if (!level) w_state_nx = D_ZERO;
      default: w_state_nx = D_ZERO;
    endcase
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Collects per-channel rising-edge events and hands them one at a time to a
// shared resource, round-robin, with overrun tracking and a done timeout.
module btn_event_arbiter #(
  parameter int N_CH        = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_CH-1:0]                       level,
  input  logic                                  req_ready,
  input  logic                                  done,
  input  logic                                  clr_ovr,
  output logic                                  req_valid,
  output logic [btn_event_arbiter_pkg::ID_W-1:0] req_id,
  output logic                                  busy,
  output logic [N_CH-1:0]                       pend,
  output logic [N_CH-1:0]                       overrun,
  output logic                                  timeout
);

  import btn_event_arbiter_pkg::*;

  localparam logic [15:0] CNT_TERM = 16'(TIMEOUT_CYC - 1);

  arb_state_e      r_state, w_state_nx;
  logic [ID_W-1:0] r_req_id, w_req_id_nx;
  logic [ID_W-1:0] r_rr_ptr, w_rr_ptr_nx;
  logic [ID_W-1:0] w_sel_id;
  logic            w_sel_vld;
  logic [15:0]     r_cnt, w_cnt_nx;
  logic            r_req_valid, r_busy, r_timeout, w_timeout_nx;
  logic            w_accept;
  logic [N_CH-1:0] r_pend, r_ovr, w_tick, w_acc_vec;

  for (genvar g = 0; g < N_CH; g++) begin : g_det
    edge_tick_cell u_det (
      .clk   (clk),
      .reset (reset),
      .level (level[g]),
      .tick  (w_tick[g])
    );
  end

  // Descending scan so the last hit written is the nearest one at/after rr_ptr.
  always_comb begin : rr_sel
    logic [ID_W-1:0] idx;
    idx       = '0;
    w_sel_vld = 1'b0;
    w_sel_id  = r_rr_ptr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = r_rr_ptr + ID_W'(k);
      if (r_pend[idx]) begin
        w_sel_vld = 1'b1;
        w_sel_id  = idx;
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_req_id_nx  = r_req_id;
    w_rr_ptr_nx  = r_rr_ptr;
    w_cnt_nx     = r_cnt;
    w_timeout_nx = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: if (w_sel_vld) begin
        w_state_nx  = S_OFFER;
        w_req_id_nx = w_sel_id;
      end
      S_OFFER: if (req_ready) begin
        w_accept   = 1'b1;
        w_state_nx = S_WAIT;
        w_cnt_nx   = '0;
      end
      S_WAIT: begin
        if (done) begin
          w_state_nx  = S_IDLE;
          w_rr_ptr_nx = r_req_id + 1'b1;
        end else if (r_cnt == CNT_TERM) begin
          w_state_nx   = S_IDLE;
          w_timeout_nx = 1'b1;
          w_rr_ptr_nx  = r_req_id + 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // A tick on the channel being accepted re-arms pend instead of counting as overrun.
  assign w_acc_vec = w_accept ? (N_CH'(1) << r_req_id) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req_id    <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_req_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_pend      <= '0;
      r_ovr       <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_req_id    <= w_req_id_nx;
      r_rr_ptr    <= w_rr_ptr_nx;
      r_cnt       <= w_cnt_nx;
      r_req_valid <= (w_state_nx == S_OFFER);
      r_busy      <= (w_state_nx != S_IDLE);
      r_timeout   <= w_timeout_nx;
      r_pend      <= (r_pend & ~w_acc_vec) | w_tick;
      r_ovr       <= (clr_ovr ? '0 : r_ovr) | (w_tick & r_pend & ~w_acc_vec);
    end
  end

  assign req_valid = r_req_valid;
  assign req_id    = r_req_id;
  assign busy      = r_busy;
  assign pend      = r_pend;
  assign overrun   = r_ovr;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a
// behavioural model of the event/grant rules.
module tb_btn_event_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset, req_ready, done, clr_ovr;
  logic [3:0] level;
  logic       req_valid, busy, timeout;
  logic [1:0] req_id;
  logic [3:0] pend, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_event_arbiter #(.N_CH(4), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .req_ready (req_ready),
    .done      (done),
    .clr_ovr   (clr_ovr),
    .req_valid (req_valid),
    .req_id    (req_id),
    .busy      (busy),
    .pend      (pend),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  // ph: 0 idle, 1 offering, 2 waiting for done
  typedef struct {
    logic [3:0] prev;
    logic [3:0] pend;
    logic [3:0] ovr;
    int         ph;
    int         id;
    int         ptr;
    int         cnt;
    logic       to;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, logic [3:0] lv, logic rdy, logic dn, logic clr);
    mstate_t    n;
    logic [3:0] rise, taken;
    bit         hit;
    n     = s;
    n.to  = 1'b0;
    rise  = lv & ~s.prev;
    taken = 4'b0;
    if (s.ph == 1 && rdy) taken[s.id] = 1'b1;
    hit = 1'b0;
    case (s.ph)
      0: begin
        for (int k = 0; k < 4; k++)
          if (!hit && s.pend[(s.ptr + k) % 4]) begin
            hit  = 1'b1;
            n.id = (s.ptr + k) % 4;
          end
        if (hit) n.ph = 1;
      end
      1: if (rdy) begin n.ph = 2; n.cnt = 0; end
      default: begin
        if (dn) begin
          n.ph = 0; n.ptr = (s.id + 1) % 4;
        end else if (s.cnt == TO - 1) begin
          n.ph = 0; n.to = 1'b1; n.ptr = (s.id + 1) % 4;
        end else begin
          n.cnt = s.cnt + 1;
        end
      end
    endcase
    n.prev = lv;
    n.pend = (s.pend & ~taken) | rise;
    n.ovr  = (clr ? 4'b0 : s.ovr) | (rise & s.pend & ~taken);
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{prev: 4'b0, pend: 4'b0, ovr: 4'b0, ph: 0, id: 0, ptr: 0, cnt: 0, to: 1'b0};
    else       m <= model_next(m, level, req_ready, done, clr_ovr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    chk({tag, ".valid"},   32'(req_valid), 32'(m.ph == 1));
    chk({tag, ".id"},      32'(req_id),    32'(m.id));
    chk({tag, ".busy"},    32'(busy),      32'(m.ph != 0));
    chk({tag, ".pend"},    32'(pend),      32'(m.pend));
    chk({tag, ".overrun"}, 32'(overrun),   32'(m.ovr));
    chk({tag, ".timeout"}, 32'(timeout),   32'(m.to));
  endtask

  initial begin
    int grants[$];

    reset = 1'b1; level = 4'b0; req_ready = 1'b0; done = 1'b0; clr_ovr = 1'b0;
    #12;
    cyc("rst");
    chk("rst.valid0", 32'(req_valid), 0);
    chk("rst.pend0", 32'(pend), 0);
    chk("rst.ovr0", 32'(overrun), 0);
    chk("rst.busy0", 32'(busy), 0);
    reset = 1'b0;

    // single event on channel 2, ready tied high
    level = 4'b0100; req_ready = 1'b1;
    cyc("t1a"); chk("t1.pend_set", 32'(pend), 32'h4); chk("t1.nvalid", 32'(req_valid), 0);
    cyc("t1b"); chk("t1.valid", 32'(req_valid), 1); chk("t1.id", 32'(req_id), 2);
    level = 4'b0;
    cyc("t1c"); chk("t1.valid_drop", 32'(req_valid), 0); chk("t1.pend_clr", 32'(pend), 0);
    chk("t1.busy", 32'(busy), 1);
    cyc("t1d"); cyc("t1e");
    done = 1'b1;
    cyc("t1f"); chk("t1.busy_fall", 32'(busy), 0);
    done = 1'b0;

    // rr_ptr is now 3; channels 0 and 3 pending -> 3 first, then 0
    req_ready = 1'b0; level = 4'b1001;
    cyc("rra"); chk("rr.pend", 32'(pend), 32'h9);
    cyc("rrb"); chk("rr.first", 32'(req_id), 3);
    req_ready = 1'b1;
    cyc("rrc");
    done = 1'b1;
    cyc("rrd");
    done = 1'b0;
    cyc("rre"); chk("rr.second_valid", 32'(req_valid), 1); chk("rr.second", 32'(req_id), 0);
    cyc("rrf");
    done = 1'b1;
    cyc("rrg");
    done = 1'b0; level = 4'b0;
    cyc("rrh");

    // fairness from a fresh reset
    reset = 1'b1;
    cyc("frst");
    reset = 1'b0; level = 4'hF; req_ready = 1'b1; done = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc("fair");
      if (req_valid) grants.push_back(int'(req_id));
    end
    chk("fair.count", 32'(grants.size()), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) chk("fair.order", 32'(grants[i]), 32'(i));
    chk("fair.noovr", 32'(overrun), 0);
    level = 4'b0; done = 1'b0;
    cyc("fend");

    // backpressure while channel 1 keeps toggling
    req_ready = 1'b0; level = 4'b0010;
    cyc("bpa"); cyc("bpb");
    for (int i = 0; i < 10; i++) begin
      level[1] = !(i == 1 || i == 4);
      cyc("bp");
      chk("bp.valid_hold", 32'(req_valid), 1);
      chk("bp.id_hold", 32'(req_id), 1);
    end
    chk("bp.ovr_set", 32'(overrun), 32'h2);
    cyc("bpc"); chk("bp.ovr_sticky", 32'(overrun), 32'h2);
    clr_ovr = 1'b1;
    cyc("bpd"); chk("bp.ovr_clr", 32'(overrun), 0);
    clr_ovr = 1'b0; req_ready = 1'b1;
    cyc("bpe");
    done = 1'b1;
    cyc("bpf");
    done = 1'b0; level = 4'b0;
    cyc("bpg");

    // timeout with done never asserted
    level = 4'b1000;
    cyc("toa"); cyc("tob");
    cyc("toc"); chk("to.in_wait", 32'(busy && !req_valid), 1);
    for (int j = 1; j < TO; j++) begin
      cyc("tow"); chk("to.early", 32'(timeout), 0);
    end
    cyc("tod"); chk("to.pulse", 32'(timeout), 1); chk("to.idle", 32'(busy), 0);
    level = 4'b0;
    cyc("toe"); chk("to.one_cycle", 32'(timeout), 0);

    // async reset mid-WAIT, channel 0 held high through it
    level = 4'b0001;
    cyc("ara"); cyc("arb"); cyc("arc"); cyc("ard");
    #2 reset = 1'b1;
    #1;
    chk("arst.valid", 32'(req_valid), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.pend", 32'(pend), 0);
    chk("arst.id", 32'(req_id), 0);
    chk("arst.timeout", 32'(timeout), 0);
    chk("arst.ovr", 32'(overrun), 0);
    cyc("are");
    reset = 1'b0;
    cyc("arf"); chk("ar.pend", 32'(pend), 32'h1); chk("ar.nvalid", 32'(req_valid), 0);
    cyc("arg"); chk("ar.regrant", 32'(req_valid), 1); chk("ar.regrant_id", 32'(req_id), 0);
    cyc("arh");
    done = 1'b1;
    cyc("ari");
    done = 1'b0; level = 4'b0; req_ready = 1'b0;
    cyc("arj");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) level[b] = ~level[b];
      req_ready = ($urandom_range(0, 3) != 0);
      done      = ($urandom_range(0, 5) == 0);
      clr_ovr   = ($urandom_range(0, 15) == 0);
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
